// File: rtl/div_unit32.sv
// 32-bit iterative restoring divider: DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Operands are latched on start; signs are restored in the DONE cycle.
module div_unit32 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q;
  logic [32:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] dvs_q;
  logic [31:0] a_q;
  logic [31:0] res_q;
  logic [1:0]  op_q;
  logic        b_neg_q, b_zero_q;

  logic        accept;
  logic        signed_op;
  logic [32:0] trial;
  logic        ge;
  logic [31:0] q_res, r_res, fix;

  function automatic logic [31:0] neg_if(input logic en, input logic [31:0] v);
    return en ? (~v + 32'd1) : v;
  endfunction

  assign accept    = (state_q == IDLE) && start;
  assign signed_op = ~op_q[0];

  // A carry out of the partial remainder means the trial value already exceeds any 32-bit divisor.
  always_comb begin
    trial = {rem_q[31:0], quo_q[31]};
    ge    = rem_q[32] | (trial >= {1'b0, dvs_q});
    rem_d = ge ? (trial - {1'b0, dvs_q}) : trial;
    quo_d = {quo_q[30:0], ge};
  end

  always_comb begin
    q_res = b_zero_q ? 32'hFFFF_FFFF : neg_if(signed_op & (a_q[31] ^ b_neg_q), quo_q);
    r_res = b_zero_q ? a_q : neg_if(signed_op & a_q[31], rem_q[31:0]);
    fix   = op_q[1] ? r_res : q_res;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = BUSY;
      BUSY:    if (cnt_q == 5'd31) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        cnt_q <= '0;
        rem_q <= '0;
      end else if (state_q == BUSY) begin
        cnt_q <= cnt_q + 5'd1;
        rem_q <= rem_d;
      end
      if (state_q == DONE) res_q <= fix;
    end
  end

  // Operand capture: signed ops work on magnitudes, signs kept for the fix-up.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q     <= op;
      a_q      <= a;
      b_neg_q  <= b[31];
      b_zero_q <= (b == 32'd0);
      quo_q    <= neg_if(~op[0] & a[31], a);
      dvs_q    <= neg_if(~op[0] & b[31], b);
    end else if (state_q == BUSY) begin
      quo_q <= quo_d;
    end
  end

  assign busy   = (state_q != IDLE);
  assign done   = (state_q == DONE);
  assign result = (state_q == DONE) ? fix : res_q;

endmodule

// File: tb/tb_div_unit32.sv
// Directed bench for div_unit32: expected results queued at start, compared at done.
module tb_div_unit32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] result;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  div_unit32 dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    if (y == 32'd0) return o[1] ? x : 32'hFFFF_FFFF;
    if (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF)
      return o[1] ? 32'h0 : 32'h8000_0000;
    case (o)
      2'b00:   return $signed(x) / $signed(y);
      2'b01:   return x / y;
      2'b10:   return $signed(x) % $signed(y);
      default: return x % y;
    endcase
  endfunction

  // One operation; inputs are scrambled after the start edge, optional ignored restart at edge N+intrude.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] expv, input int intrude);
    int lat;
    int extra;
    logic [31:0] want;
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    exp_q.push_back(expv);
    @(posedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom; op = 2'($urandom);
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    lat = 0;
    for (int k = 1; k <= 40 && lat == 0; k++) begin
      if (k == intrude) begin start = 1'b1; a = 32'd1; b = 32'd1; op = 2'b01; end
      @(posedge clk); #1;
      start = 1'b0;
      if (done) lat = k;
    end
    chk({tag, "_latency"}, 32'(lat), 32'd32);
    want = exp_q.pop_front();
    chk({tag, "_result"}, result, want);
    @(posedge clk); #1;
    chk({tag, "_done_low"}, 32'(done), 32'd0);
    chk({tag, "_idle"}, 32'(busy), 32'd0);
    chk({tag, "_held"}, result, want);
    if (intrude != 0) begin
      extra = 0;
      for (int k = 0; k < 40; k++) begin
        @(posedge clk); #1;
        if (done) extra++;
      end
      chk({tag, "_no_2nd_done"}, 32'(extra), 32'd0);
    end
  endtask

  initial begin
    int dones;
    logic [31:0] rx, ry;
    logic [1:0]  ro;
    rst_n = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", result, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    run_op("divu_100_7",  2'b01, 32'd100, 32'd7, 32'h0000_000E, 0);
    run_op("remu_100_7",  2'b11, 32'd100, 32'd7, 32'h0000_0002, 0);
    run_op("div_m7_2",    2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 0);
    run_op("rem_m7_2",    2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 0);
    run_op("divu_by0",    2'b01, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 0);
    run_op("rem_by0",     2'b10, 32'h1234_5678, 32'd0, 32'h1234_5678, 0);
    run_op("div_by0_neg", 2'b00, 32'hFFFF_FFF0, 32'd0, 32'hFFFF_FFFF, 0);
    run_op("div_ovf",     2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
    run_op("rem_ovf",     2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 0);
    run_op("div_7_m2",    2'b00, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 0);
    run_op("rem_7_m2",    2'b10, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 0);
    run_op("divu_big",    2'b01, 32'hFFFF_FFFF, 32'h0000_0003, 32'h5555_5555, 0);
    run_op("divu_restart", 2'b01, 32'd100, 32'd7, 32'h0000_000E, 5);

    for (int i = 0; i < 6; i++) begin
      rx = $urandom; ry = $urandom >> (i * 5); ro = 2'(i);
      run_op("random", ro, rx, ry, model(ro, rx, ry), 0);
    end

    // Abort mid-operation with reset.
    @(negedge clk);
    op = 2'b00; a = 32'd1000; b = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_result", result, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    dones = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    chk("abort_no_done", 32'(dones), 32'd0);
    run_op("divu_9_3", 2'b01, 32'd9, 32'd3, 32'h0000_0003, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
